mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-port arbiter and sequencer that shares the single-ported word memory controller between instruction fetch (port I) and load/store (port D).
- Accepts requests, picks one, and latches its address, direction and write data.
- Issues exactly one valid pulse to the memory controller, waits the fixed memory latency, then returns read data and a done pulse to the granted requester.
- Sits between the CPU core and the memory controller.

Parameters:
- DWIDTH, 32, data word width.
- CPUAWIDTH, 32, CPU byte-address width.
- MEM_LAT, 2, memory-controller cycles from valid pulse to read data stable (1..15).

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- i_req  input  1  port I request (level)
- i_addr  input  CPUAWIDTH  port I byte address (read only)
- i_gnt  output  1  port I grant pulse
- i_done  output  1  port I completion pulse
- d_req  input  1  port D request (level)
- d_rw  input  1  port D direction, 1=read, 0=write
- d_addr  input  CPUAWIDTH  port D byte address
- d_wdata  input  DWIDTH  port D write data
- d_gnt  output  1  port D grant pulse
- d_done  output  1  port D completion pulse
- rdata  output  DWIDTH  read data for the completing port
- busy  output  1  transaction in flight
- mem_valid  output  1  one-cycle request pulse to the memory controller
- mem_rw  output  1  to controller, 1=read
- mem_addr  output  CPUAWIDTH  to controller
- mem_wdata  output  DWIDTH  write data to controller
- mem_wr_oe  output  1  enables top-level tristate driver of the shared data bus
- mem_rdata  input  DWIDTH  data bus value from the controller

Behaviour:
- Reset: all outputs 0; state=IDLE; wait counter=0; last-grant pointer=I.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Sample i_req and d_req.
  - If either is high, select a winner, latch its addr/rw/wdata (port I: rw=1, wdata=0) and the owner ID, assert the owner's gnt for the next cycle, and go to ISSUE.
  - If neither is high, stay in IDLE.
- ISSUE (1 cycle): mem_valid=1, mem_rw/mem_addr/mem_wdata from the latched values, gnt of the owner=1. Counter loads MEM_LAT-1. Go to WAIT.
- WAIT: mem_rw/mem_addr/mem_wdata are held. mem_wr_oe=1 for writes.
  - If counter=0, capture mem_rdata into rdata on reads (writes leave rdata unchanged) and go to DONE.
  - Otherwise decrement the counter.
- DONE (1 cycle): the owner's done=1, then return to IDLE.
- mem_addr is held through WAIT because the memory controller re-samples it.
- Timing: request sampled at edge k → gnt and mem_valid high in cycle k+1 → done high in cycle k+2+MEM_LAT. One transaction every MEM_LAT+3 cycles maximum.
- Requesters may change addr/data after seeing gnt.
- If req is still high during DONE, it is treated as a new request at the following IDLE.
- busy=1 in ISSUE, WAIT and DONE.
- At most one gnt and one done are high in any cycle. mem_valid never occurs outside ISSUE.
- Requests arriving while busy are not lost as long as the level is held; they are arbitrated in the next IDLE.
- Address is passed through unmodified; the controller drops bits [1:0].
- Reset asserted mid-transaction: next edge forces IDLE and clears all outputs with no done pulse. rdata is cleared to 0.
- Default arbitration (macro undefined): fixed priority, D beats I.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin arbitration. On a simultaneous request, the port not granted last wins. The last-grant pointer updates on every grant and resets to I, so D wins the first tie after reset.
- Undefined: fixed priority, D always wins ties; the pointer logic is absent.

Test Plan:
- MEM_LAT=2, i_req only with i_addr=0x0000_0010, mem_rdata=0xDEAD_BEEF → i_gnt and mem_valid (mem_rw=1, mem_addr=0x10) in cycle k+1; i_done with rdata=0xDEAD_BEEF in cycle k+4; d_gnt/d_done never asserted.
- d_req write, d_addr=0x20, d_wdata=0x1234_5678 → mem_rw=0 and mem_wdata=0x1234_5678 in ISSUE; mem_wr_oe=1 for 2 WAIT cycles; d_done in cycle k+4; rdata unchanged.
- i_req and d_req held high together for 3 transactions, macro undefined → grant order D,D,D. With MEM_ARB_RR_EN → D,I,D.
- d_req raised while an I read is in WAIT → I completes first; d_gnt follows in the cycle after i_done+1; no overlapping mem_valid.
- Reset asserted in the second WAIT cycle → next cycle busy=0, no done, rdata=0. A fresh i_req then completes normally in 4 cycles.
- MEM_LAT=1 and MEM_LAT=15 builds → done exactly MEM_LAT+2 cycles after the request edge.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares the single-ported word memory controller between instruction fetch
// (port I, read only) and load/store (port D). It picks one requester, latches
// its address, direction and write data, then issues one mem_valid pulse. It
// waits MEM_LAT cycles and returns read data with a done pulse to the owner.
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   i_req/i_addr        : port I request level and byte address
//   i_gnt/i_done        : port I grant / completion pulses
//   d_req/d_rw/d_addr/d_wdata : port D request, direction (1=read), address, data
//   d_gnt/d_done        : port D grant / completion pulses
//   rdata               : read data of the most recent completed read
//   busy                : high in ISSUE, WAIT and DONE
//   mem_valid/mem_rw/mem_addr/mem_wdata : request to the memory controller
//   mem_wr_oe           : enables the top-level tristate driver during writes
//   mem_rdata           : data bus value from the controller
//
// Build option
//   MEM_ARB_RR_EN : when defined, ties are broken round-robin (the port not
//                   granted last wins). When undefined, D always wins ties.

module mem_arbiter #(
  parameter int DWIDTH    = 32,
  parameter int CPUAWIDTH = 32,
  parameter int MEM_LAT   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_req,
  input  logic [CPUAWIDTH-1:0] i_addr,
  output logic                 i_gnt,
  output logic                 i_done,
  input  logic                 d_req,
  input  logic                 d_rw,
  input  logic [CPUAWIDTH-1:0] d_addr,
  input  logic [DWIDTH-1:0]    d_wdata,
  output logic                 d_gnt,
  output logic                 d_done,
  output logic [DWIDTH-1:0]    rdata,
  output logic                 busy,
  output logic                 mem_valid,
  output logic                 mem_rw,
  output logic [CPUAWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0]    mem_wdata,
  output logic                 mem_wr_oe,
  input  logic [DWIDTH-1:0]    mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t                 state_reg, state_next;
  logic [3:0]             cnt_reg;
  logic                   owner_d_reg;   // 0 = port I owns the transaction, 1 = port D
  logic                   rw_reg;
  logic [CPUAWIDTH-1:0]   addr_reg;
  logic [DWIDTH-1:0]      wdata_reg;
  logic [DWIDTH-1:0]      rdata_reg;
  logic                   any_req;
  logic                   pick_d;

  assign any_req = i_req | d_req;

`ifdef MEM_ARB_RR_EN
  // Set when the previous grant went to D; reset points at I so that
  // D wins the first tie after reset.
  logic last_d_reg;

  assign pick_d = d_req & (~i_req | ~last_d_reg);

  always_ff @(posedge clk) begin
    if (reset) begin
      last_d_reg <= 1'b0;
    end else if (state_reg == IDLE && any_req) begin
      last_d_reg <= pick_d;
    end
  end
`else
  assign pick_d = d_req;
`endif

  // State register and latched transaction context
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      owner_d_reg <= 1'b0;
      rw_reg      <= 1'b0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      rdata_reg   <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (any_req) begin
            owner_d_reg <= pick_d;
            rw_reg      <= pick_d ? d_rw    : 1'b1;
            addr_reg    <= pick_d ? d_addr  : i_addr;
            wdata_reg   <= pick_d ? d_wdata : '0;
          end
        end
        ISSUE: begin
          cnt_reg <= 4'(MEM_LAT - 1);
        end
        WAIT: begin
          if (cnt_reg == 4'd0) begin
            // Writes leave the last read value visible on rdata.
            if (rw_reg) begin
              rdata_reg <= mem_rdata;
            end
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Next state and outputs
  always_comb begin
    state_next = state_reg;
    i_gnt      = 1'b0;
    d_gnt      = 1'b0;
    i_done     = 1'b0;
    d_done     = 1'b0;
    mem_valid  = 1'b0;
    mem_wr_oe  = 1'b0;
    busy       = 1'b1;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (any_req) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        mem_valid  = 1'b1;
        i_gnt      = ~owner_d_reg;
        d_gnt      = owner_d_reg;
        state_next = WAIT;
      end
      WAIT: begin
        mem_wr_oe = ~rw_reg;
        if (cnt_reg == 4'd0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        i_done     = ~owner_d_reg;
        d_done     = owner_d_reg;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The controller re-samples the address during WAIT, so the latched
  // context is driven continuously rather than only during ISSUE.
  assign mem_rw    = rw_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign rdata     = rdata_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with literal
// expectations plus randomized traffic compared against a transaction-level
// model every cycle.
module tb_mem_arbiter;
  parameter int LAT = 2;
  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_gnt, i_done;
  logic          d_req, d_rw;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt, d_done;
  logic [DW-1:0] rdata;
  logic          busy, mem_valid, mem_rw, mem_wr_oe;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.DWIDTH(DW), .CPUAWIDTH(AW), .MEM_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_done(i_done),
    .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_done(d_done), .rdata(rdata), .busy(busy),
    .mem_valid(mem_valid), .mem_rw(mem_rw), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wr_oe(mem_wr_oe), .mem_rdata(mem_rdata)
  );

  // ---------------- behavioural model ----------------
  // m_t counts cycles since the grant: 0 = idle, 1 = grant/issue cycle,
  // 2..LAT+1 = memory latency window, LAT+2 = completion cycle.
  int            m_t;
  bit            m_own_d, m_rw, m_last_d;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;

  function automatic bit model_pick_d(bit ir, bit dr, bit last_d);
    if (ir && dr) begin
`ifdef MEM_ARB_RR_EN
      return !last_d;
`else
      return 1'b1;
`endif
    end
    return dr;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_t <= 0; m_rdata <= '0; m_last_d <= 1'b0;
      m_own_d <= 1'b0; m_rw <= 1'b0; m_addr <= '0; m_wdata <= '0;
    end else if (m_t == 0) begin
      if (i_req || d_req) begin
        m_t      <= 1;
        m_own_d  <= model_pick_d(i_req, d_req, m_last_d);
        m_last_d <= model_pick_d(i_req, d_req, m_last_d);
        if (model_pick_d(i_req, d_req, m_last_d)) begin
          m_rw <= d_rw; m_addr <= d_addr; m_wdata <= d_wdata;
        end else begin
          m_rw <= 1'b1; m_addr <= i_addr; m_wdata <= '0;
        end
      end
    end else if (m_t == LAT + 2) begin
      m_t <= 0;
    end else begin
      if (m_t == LAT + 1 && m_rw) m_rdata <= mem_rdata;
      m_t <= m_t + 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s t=%0t actual=0x%0h required=0x%0h", name, $time, act, exp);
  endtask

  // Advance one cycle and compare every output against the model.
  task automatic tick();
    bit e_iss, e_wait, e_done;
    @(negedge clk);
    e_iss  = (m_t == 1);
    e_wait = (m_t >= 2) && (m_t <= LAT + 1);
    e_done = (m_t == LAT + 2);
    chk("busy",      64'(busy),      64'(m_t != 0));
    chk("mem_valid", 64'(mem_valid), 64'(e_iss));
    chk("i_gnt",     64'(i_gnt),     64'(e_iss && !m_own_d));
    chk("d_gnt",     64'(d_gnt),     64'(e_iss && m_own_d));
    chk("i_done",    64'(i_done),    64'(e_done && !m_own_d));
    chk("d_done",    64'(d_done),    64'(e_done && m_own_d));
    chk("mem_wr_oe", 64'(mem_wr_oe), 64'(e_wait && !m_rw));
    chk("rdata",     64'(rdata),     64'(m_rdata));
    if (e_iss || e_wait) begin
      chk("mem_rw",    64'(mem_rw),    64'(m_rw));
      chk("mem_addr",  64'(mem_addr),  64'(m_addr));
      chk("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    int ng;
    bit order [4];
    int t_idone, t_dgnt;

    reset = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_rw = 1'b1;
    d_addr = '0; d_wdata = '0; mem_rdata = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_busy",  64'(busy),     64'(0));
    chk("rst_addr",  64'(mem_addr), 64'(0));
    chk("rst_rdata", 64'(rdata),    64'(0));
    chk("rst_rw",    64'(mem_rw),   64'(0));
    $display("txn reset: outputs cleared");

    // I read
    mem_rdata = 32'hDEAD_BEEF; i_addr = 32'h10; i_req = 1'b1;
    tick();
    chk("t1_gnt",   64'(i_gnt),     64'(1));
    chk("t1_valid", 64'(mem_valid), 64'(1));
    chk("t1_rw",    64'(mem_rw),    64'(1));
    chk("t1_addr",  64'(mem_addr),  64'h10);
    i_req = 1'b0;
    for (int i = 0; i < LAT + 1; i++) tick();
    chk("t1_done",  64'(i_done), 64'(1));
    chk("t1_ddone", 64'(d_done), 64'(0));
    chk("t1_rdata", 64'(rdata),  64'hDEAD_BEEF);
    $display("txn I read addr=0x10 rdata=0x%08h", rdata);
    tick();

    // D write
    d_req = 1'b1; d_rw = 1'b0; d_addr = 32'h20; d_wdata = 32'h1234_5678;
    tick();
    chk("t2_gnt",   64'(d_gnt),     64'(1));
    chk("t2_rw",    64'(mem_rw),    64'(0));
    chk("t2_wdata", 64'(mem_wdata), 64'h1234_5678);
    d_req = 1'b0;
    cnt = 0;
    for (int i = 0; i < LAT; i++) begin
      tick();
      if (mem_wr_oe) cnt++;
    end
    chk("t2_oe_cycles", 64'(cnt), 64'(LAT));
    tick();
    chk("t2_done",  64'(d_done), 64'(1));
    chk("t2_rdata", 64'(rdata),  64'hDEAD_BEEF);
    $display("txn D write addr=0x20 wdata=0x12345678 oe_cycles=%0d", cnt);
    tick();

    // Reset during the second latency cycle
    mem_rdata = 32'h55; i_addr = 32'h44; i_req = 1'b1;
    tick();
    i_req = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    chk("t5_busy",  64'(busy),   64'(0));
    chk("t5_done",  64'(i_done), 64'(0));
    chk("t5_rdata", 64'(rdata),  64'(0));
    reset = 1'b0;
    i_addr = 32'h48; i_req = 1'b1;
    tick();
    i_req = 1'b0;
    for (int i = 0; i < LAT + 1; i++) tick();
    chk("t5_fresh_done",  64'(i_done), 64'(1));
    chk("t5_fresh_rdata", 64'(rdata),  64'h55);
    $display("txn reset mid-flight then I read rdata=0x%08h", rdata);
    tick();

    // Simultaneous requests held for three transactions
    i_addr = 32'h100; d_rw = 1'b1; d_addr = 32'h200; i_req = 1'b1; d_req = 1'b1;
    ng = 0;
    for (int i = 0; i < 4 * (LAT + 3); i++) begin
      tick();
      if (i_gnt || d_gnt) begin
        if (ng < 4) order[ng] = d_gnt;
        ng++;
        if (ng == 3) begin i_req = 1'b0; d_req = 1'b0; end
      end
    end
    chk("t3_count", 64'(ng), 64'(3));
    chk("t3_g0", 64'(order[0]), 64'(1));
`ifdef MEM_ARB_RR_EN
    chk("t3_g1", 64'(order[1]), 64'(0));
`else
    chk("t3_g1", 64'(order[1]), 64'(1));
`endif
    chk("t3_g2", 64'(order[2]), 64'(1));
    $display("txn tie grants D?=%0d,%0d,%0d", order[0], order[1], order[2]);

    // D request arriving while an I read is in flight
    i_addr = 32'h80; i_req = 1'b1;
    tick();
    i_req = 1'b0;
    tick();
    d_req = 1'b1; d_rw = 1'b1; d_addr = 32'h90;
    t_idone = -1; t_dgnt = -1;
    for (int i = 0; i < 4 * (LAT + 3) && t_dgnt < 0; i++) begin
      tick();
      if (i_done) t_idone = i;
      if (d_gnt) begin t_dgnt = i; d_req = 1'b0; end
    end
    chk("t4_idone_seen", 64'(t_idone >= 0), 64'(1));
    chk("t4_dgnt_gap",   64'(t_dgnt - t_idone), 64'(2));
    $display("txn D behind I: i_done@%0d d_gnt@%0d", t_idone, t_dgnt);
    for (int i = 0; i < LAT + 3; i++) tick();

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      i_req     = ($urandom_range(0, 2) == 0);
      d_req     = ($urandom_range(0, 2) == 0);
      d_rw      = $urandom_range(0, 1) == 1;
      i_addr    = $urandom;
      d_addr    = $urandom;
      d_wdata   = $urandom;
      mem_rdata = $urandom;
      reset     = ($urandom_range(0, 149) == 0);
      tick();
      if (i_gnt || d_gnt)
        $display("txn rand grant %s addr=0x%08h rw=%0d", d_gnt ? "D" : "I", mem_addr, mem_rw);
    end
    reset = 1'b0; i_req = 1'b0; d_req = 1'b0;
    for (int i = 0; i < LAT + 4; i++) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
